// File: rtl/fpu_sched_pkg.sv
`default_nettype none
// ============================================================================
// fpu_sched_pkg : shared types and default latencies for the FP WB scheduler
// Revision 1.0
// ============================================================================
package fpu_sched_pkg;

  localparam int DEF_TAG_W     = 7;
  localparam int DEF_FMA_LAT   = 4;
  localparam int DEF_FAST_LAT  = 2;
  localparam int DEF_TOINT_LAT = 1;

  typedef enum logic [2:0] {
    CLS_FMA     = 3'd0,
    CLS_FAST    = 3'd1,
    CLS_FROMINT = 3'd2,
    CLS_TOINT   = 3'd3,
    CLS_ILLEGAL = 3'd4
  } fpu_cls_e;

  typedef struct packed {
    logic       ren2;
    logic       ren3;
    logic       swap23;
    logic       fromint;
    logic       toint;
    logic       fastpipe;
    logic       fma;
    logic       wflags;
    logic [1:0] typeTagIn;
    logic [1:0] typeTagOut;
  } fpu_sigs_t;

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [1:0]           typeTag;
    logic                 wflags;
  } wb_slot_t;

  function automatic fpu_cls_e fpu_classify(input fpu_sigs_t s);
    if (s.fma)           return CLS_FMA;
    else if (s.fastpipe) return CLS_FAST;
    else if (s.fromint)  return CLS_FROMINT;
    else if (s.toint)    return CLS_TOINT;
    else                 return CLS_ILLEGAL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_wb_slot_pipe.sv
`default_nettype none
// ============================================================================
// fpu_wb_slot_pipe : writeback reservation shift register, slot 0 is the head
// Revision 1.0
// ============================================================================
module fpu_wb_slot_pipe
  import fpu_sched_pkg::*;
#(
  parameter int DEPTH = DEF_FMA_LAT,
  parameter int TAG_W = DEF_TAG_W,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             kill_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [1:0]       wr_type_i,
  input  logic             wr_wflags_i,
  input  logic [IDX_W-1:0] query_idx_i,
  output logic             query_occ_o,
  output logic             head_valid_o,
  output logic [TAG_W-1:0] head_tag_o,
  output logic [1:0]       head_type_o,
  output logic             head_wflags_o,
  output logic             busy_o
);

  // Same field layout as wb_slot_t, sized to this instance's tag width.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       typeTag;
    logic             wflags;
  } slot_t;

  slot_t slots_q  [DEPTH];
  slot_t slots_d  [DEPTH];
  slot_t shifted  [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) shifted[i] = '0;
    for (int i = 0; i < DEPTH - 1; i++) shifted[i] = slots_q[i+1];

    query_occ_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      slots_d[i] = shifted[i];
      if (query_idx_i == IDX_W'(i)) query_occ_o = shifted[i].valid;
      if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
        slots_d[i].valid   = 1'b1;
        slots_d[i].tag     = wr_tag_i;
        slots_d[i].typeTag = wr_type_i;
        slots_d[i].wflags  = wr_wflags_i;
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy_o = busy_o | slots_q[i].valid;
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      slots_q[i] <= (reset || kill_i) ? '0 : slots_d[i];
    end
  end

  assign head_valid_o  = slots_q[0].valid;
  assign head_tag_o    = slots_q[0].tag;
  assign head_type_o   = slots_q[0].typeTag;
  assign head_wflags_o = slots_q[0].wflags;

endmodule
`default_nettype wire

// File: rtl/fpu_wb_scheduler.sv
`default_nettype none
// ============================================================================
// fpu_wb_scheduler : FP uop issue with collision-free writeback reservation
// Revision 1.0
// ============================================================================
module fpu_wb_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int TAG_W     = DEF_TAG_W,
  parameter int FMA_LAT   = DEF_FMA_LAT,
  parameter int FAST_LAT  = DEF_FAST_LAT,
  parameter int TOINT_LAT = DEF_TOINT_LAT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_valid,
  output logic             io_req_ready,
  input  logic [TAG_W-1:0] io_req_bits_tag,
  input  logic             io_req_bits_sigs_ren2,
  input  logic             io_req_bits_sigs_ren3,
  input  logic             io_req_bits_sigs_swap23,
  input  logic             io_req_bits_sigs_fromint,
  input  logic             io_req_bits_sigs_toint,
  input  logic             io_req_bits_sigs_fastpipe,
  input  logic             io_req_bits_sigs_fma,
  input  logic             io_req_bits_sigs_wflags,
  input  logic [1:0]       io_req_bits_sigs_typeTagIn,
  input  logic [1:0]       io_req_bits_sigs_typeTagOut,
  input  logic             io_kill,
  output logic             io_fpwb_valid,
  output logic [TAG_W-1:0] io_fpwb_tag,
  output logic [1:0]       io_fpwb_typeTag,
  output logic             io_fpwb_wflags,
  output logic             io_intwb_valid,
  output logic [TAG_W-1:0] io_intwb_tag,
  output logic             io_intwb_wflags,
  output logic             io_illegal,
  output logic             io_busy
);

  localparam int FP_IDX_W  = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;
  localparam int INT_IDX_W = (TOINT_LAT > 1) ? $clog2(TOINT_LAT) : 1;
  localparam logic [FP_IDX_W-1:0]  FMA_SLOT   = FP_IDX_W'(FMA_LAT - 1);
  localparam logic [FP_IDX_W-1:0]  FAST_SLOT  = FP_IDX_W'(FAST_LAT - 1);
  localparam logic [INT_IDX_W-1:0] TOINT_SLOT = INT_IDX_W'(TOINT_LAT - 1);

  generate
    if ((FAST_LAT < 1) || (FAST_LAT > FMA_LAT) || (TOINT_LAT < 1) || (TOINT_LAT > FMA_LAT))
    begin : g_bad_latency_cfg
      $error("fpu_wb_scheduler: FAST_LAT and TOINT_LAT must lie in [1, FMA_LAT]");
    end
  endgenerate

  fpu_sigs_t              sigs_w;
  fpu_cls_e               cls_w;
  logic [FP_IDX_W-1:0]    fp_query_w;
  logic                   fp_occ_w;
  logic                   int_occ_w;
  logic                   slot_free_w;
  logic                   fire_w;
  logic                   fp_wr_w;
  logic                   int_wr_w;
  logic                   fp_busy_w;
  logic                   int_busy_w;
  logic [1:0]             int_type_unused_w;
  logic                   illegal_d;
  logic                   illegal_q;

  assign sigs_w = '{
    ren2:       io_req_bits_sigs_ren2,
    ren3:       io_req_bits_sigs_ren3,
    swap23:     io_req_bits_sigs_swap23,
    fromint:    io_req_bits_sigs_fromint,
    toint:      io_req_bits_sigs_toint,
    fastpipe:   io_req_bits_sigs_fastpipe,
    fma:        io_req_bits_sigs_fma,
    wflags:     io_req_bits_sigs_wflags,
    typeTagIn:  io_req_bits_sigs_typeTagIn,
    typeTagOut: io_req_bits_sigs_typeTagOut
  };

  assign cls_w      = fpu_classify(sigs_w);
  assign fp_query_w = (cls_w == CLS_FMA) ? FMA_SLOT : FAST_SLOT;

  // The to-int pipe's top slot is always free after the shift; the query is kept for symmetry.
  always_comb begin
    case (cls_w)
      CLS_FMA, CLS_FAST, CLS_FROMINT: slot_free_w = ~fp_occ_w;
      CLS_TOINT:                      slot_free_w = ~int_occ_w;
      default:                        slot_free_w = 1'b1;
    endcase
    io_req_ready = ~reset & ~io_kill & slot_free_w;
  end

  assign fire_w   = io_req_valid & io_req_ready;
  assign fp_wr_w  = fire_w & ((cls_w == CLS_FMA) | (cls_w == CLS_FAST) | (cls_w == CLS_FROMINT));
  assign int_wr_w = fire_w & (cls_w == CLS_TOINT);
  assign illegal_d = fire_w & (cls_w == CLS_ILLEGAL);

  always_ff @(posedge clock) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  fpu_wb_slot_pipe #(
    .DEPTH (FMA_LAT),
    .TAG_W (TAG_W),
    .IDX_W (FP_IDX_W)
  ) u_fp_pipe (
    .clock         (clock),
    .reset         (reset),
    .kill_i        (io_kill),
    .wr_en_i       (fp_wr_w),
    .wr_idx_i      (fp_query_w),
    .wr_tag_i      (io_req_bits_tag),
    .wr_type_i     (io_req_bits_sigs_typeTagOut),
    .wr_wflags_i   (io_req_bits_sigs_wflags),
    .query_idx_i   (fp_query_w),
    .query_occ_o   (fp_occ_w),
    .head_valid_o  (io_fpwb_valid),
    .head_tag_o    (io_fpwb_tag),
    .head_type_o   (io_fpwb_typeTag),
    .head_wflags_o (io_fpwb_wflags),
    .busy_o        (fp_busy_w)
  );

  fpu_wb_slot_pipe #(
    .DEPTH (TOINT_LAT),
    .TAG_W (TAG_W),
    .IDX_W (INT_IDX_W)
  ) u_int_pipe (
    .clock         (clock),
    .reset         (reset),
    .kill_i        (io_kill),
    .wr_en_i       (int_wr_w),
    .wr_idx_i      (TOINT_SLOT),
    .wr_tag_i      (io_req_bits_tag),
    .wr_type_i     (2'b00),
    .wr_wflags_i   (io_req_bits_sigs_wflags),
    .query_idx_i   (TOINT_SLOT),
    .query_occ_o   (int_occ_w),
    .head_valid_o  (io_intwb_valid),
    .head_tag_o    (io_intwb_tag),
    .head_type_o   (int_type_unused_w),
    .head_wflags_o (io_intwb_wflags),
    .busy_o        (int_busy_w)
  );

  assign io_illegal = illegal_q;
  assign io_busy    = fp_busy_w | int_busy_w;

endmodule
`default_nettype wire

// File: doc/fpu_wb_scheduler.md
# fpu_wb_scheduler

Issue-side scheduler between the FP uop decoder and the FPU datapath pipes. It accepts one uop per cycle, carrying a ROB tag and the decoded FPU control-signal bundle. It routes the uop to the FMA, fast, from-int or to-int pipe model, and reserves writeback slots so that no two results collide on the single FP writeback port. At fixed latency it emits FP- and integer-writeback strobes with the tag, typeTag and flags-write bit.

## Interface
Parameters:
- TAG_W, 7: ROB tag width.
- FMA_LAT, 4: FMA pipe latency, in cycles from accept to writeback.
- FAST_LAT, 2: latency of the fastpipe and from-int pipes.
- TOINT_LAT, 1: latency of the to-int pipe.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- io_req_valid  in  1  uop offered.
- io_req_ready  out  1  uop accepted when ready and valid are both high.
- io_req_bits_tag  in  TAG_W  ROB tag.
- io_req_bits_sigs_ren2, _ren3, _swap23, _fromint, _toint, _fastpipe, _fma, _wflags  in  1 each  decoded control bits.
- io_req_bits_sigs_typeTagIn, _typeTagOut  in  2 each  format tags.
- io_kill  in  1  flush of all in-flight uops.
- io_fpwb_valid  out  1  FP register-file writeback strobe.
- io_fpwb_tag  out  TAG_W  tag of the FP result.
- io_fpwb_typeTag  out  2  typeTagOut of the FP result.
- io_fpwb_wflags  out  1  the result updates fflags.
- io_intwb_valid  out  1  integer register-file writeback strobe.
- io_intwb_tag  out  TAG_W  tag of the integer result.
- io_intwb_wflags  out  1  the integer result updates fflags.
- io_illegal  out  1  one-cycle pulse for a uop that selects no class.
- io_busy  out  1  at least one uop is in flight.

## Operation
- Class select, in priority order: fma → FMA; else fastpipe → FAST; else fromint → FROMINT; else toint → TOINT; else ILLEGAL.
- FP writeback reservation: shift register of FMA_LAT slots. Each slot holds valid, tag, typeTag and wflags. The register shifts toward slot 0 every cycle; slot 0 drives the io_fpwb_* outputs.
- On accepting an FMA uop, slot FMA_LAT-1 is written. On accepting a FAST or FROMINT uop, slot FAST_LAT-1 is written.
- Integer pipe: TOINT_LAT-deep shift register driving the io_intwb_* outputs. It has a single producer, so it never conflicts.
- io_req_ready is combinational from the request bits and the reservation state:
  - low when reset or io_kill is high;
  - for FMA, FAST and FROMINT uops, low when the target slot, after this cycle's shift, is already occupied;
  - high for TOINT and ILLEGAL uops.
- An ILLEGAL uop is accepted and dropped. io_illegal is registered high for the following cycle. No writeback is produced.
- ren2, ren3, swap23 and typeTagIn are not stored. They are consumed by the operand-read stage.
- io_kill clears every slot in both pipes at the next edge. A uop offered in the kill cycle is not accepted.
- io_busy is the OR of all slot valids in both pipes.

## Timing
- Reset values: every slot valid is 0. io_fpwb_valid, io_intwb_valid, io_illegal and io_busy are 0. All tag, typeTag and wflags outputs are 0.
- A uop accepted at the edge ending cycle t produces writeback valid during cycle t+LAT of its class.
- All writeback outputs are driven directly from registers; there is no combinational path from the request to the writeback outputs.
- Simultaneous events in one cycle: the shift, a new reservation and kill. Kill wins: all slots are cleared and nothing is written.
- A writeback being presented in the kill cycle is still valid in that cycle; the kill only clears slots at the following edge.
- Reset asserted mid-operation clears all state at the next edge. Outputs are at their reset values in the following cycle.
- Configuration constraint: FAST_LAT and TOINT_LAT are each at least 1 and no greater than FMA_LAT. An elaboration assertion enforces this.

## Structure
- Package fpu_sched_pkg holds:
  - the class enum (FMA, FAST, FROMINT, TOINT, ILLEGAL);
  - the packed fpu_sigs_t struct matching the decoder output bundle;
  - the packed wb_slot_t struct (valid, tag, typeTag, wflags);
  - the default latency constants.
- Sub-module fpu_wb_slot_pipe, parameterized by DEPTH and TAG_W:
  - shift register of wb_slot_t with a write port at an arbitrary index;
  - a kill input;
  - an occupancy query that reports the post-shift occupancy of a given index.
- The FP pipe and the integer pipe are each one instance of fpu_wb_slot_pipe. The top level keeps only class select, ready logic and the illegal flag.

## Test plan
- FMA uop, tag 5, wflags 1, typeTagOut 1, accepted at cycle 0 → io_fpwb_valid high only in cycle 4, tag 5, typeTag 1, wflags 1; io_busy high for cycles 1–4.
- FMA uop tag 3 accepted at cycle 0, then FAST uop tag 4 offered from cycle 2 → io_req_ready low in cycle 2, accepted in cycle 3; writebacks: tag 3 in cycle 4, tag 4 in cycle 5.
- TOINT uop tag 9 at cycle 0 and FAST uop tag 10 at cycle 1 → io_intwb_valid with tag 9 in cycle 1; io_fpwb_valid with tag 10 in cycle 3; no stall.
- FMA uop tag 7 at cycle 0, io_kill high in cycle 2 → no writeback in cycle 4; io_busy low from cycle 3; a uop offered in cycle 2 is not accepted.
- Uop with all class bits 0 at cycle 0 → ready high, io_illegal high only in cycle 1, no writeback of either kind.
- Two FMA uops accepted at cycles 0 and 1, reset high in cycle 2 → all outputs 0 from cycle 3; no writeback in cycle 4 or 5.
